// File: rtl/code_packer.sv
// code_packer
//
// Packs successive strobed codes from the upstream code stage LSB-first into
// a wider word and presents finished words on a valid/ready output.
// The output holding register is single-entry. While it is occupied and the
// accumulator is full, new codes are dropped and counted in a saturating
// counter. A flush request emits a partially filled word.
//
// Optional feature (macro CODE_PACKER_PARITY_EN):
//   When defined, adds out_par_o, the XOR of all bits of out_data_o. It is
//   registered alongside the data.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   in_code_i   code from the upstream stage
//   in_vld_i    strobe; in_code_i valid this cycle (no upstream backpressure)
//   flush_i     request emission of a partial word
//   out_data_o  packed word; slot k is bits [k*CODE_W +: CODE_W]
//   out_cnt_o   number of valid codes in out_data_o (1..PACK_N)
//   out_vld_o   out_data_o/out_cnt_o valid
//   out_rdy_i   downstream accepts when out_vld_o && out_rdy_i
//   drop_cnt_o  saturating count of dropped codes
//   busy_o      accumulator non-empty, output valid, or flush pending
//   out_par_o   (CODE_PACKER_PARITY_EN only) parity of out_data_o
//
// Handshake: a word is consumed on a rising edge where out_vld_o && out_rdy_i.
// out_data_o/out_cnt_o stay stable while out_vld_o && !out_rdy_i.
module code_packer #(
    parameter int CODE_W = 3,
    parameter int PACK_N = 4,
    parameter int CNT_W  = 8,
    localparam int OUT_W = CODE_W * PACK_N,
    localparam int NW    = $clog2(PACK_N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in_code_i,
    input  logic              in_vld_i,
    input  logic              flush_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic [NW-1:0]     out_cnt_o,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic [CNT_W-1:0]  drop_cnt_o,
`ifdef CODE_PACKER_PARITY_EN
    output logic              out_par_o,
`endif
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d, acc_w;
    logic [NW-1:0]      cnt_q, cnt_d, cnt_w;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [NW-1:0]      out_cnt_q, out_cnt_d;
    logic               out_vld_q, out_vld_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               out_free;
    logic               xfer;
    logic [OUT_W-1:0]   xfer_word;
    logic [NW-1:0]      xfer_cnt;

    always_comb begin
        out_free  = !out_vld_q || out_rdy_i;
        acc_w     = acc_q;
        cnt_w     = cnt_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        xfer      = 1'b0;
        xfer_word = acc_q;
        xfer_cnt  = cnt_q;

        case (state_q)
            IDLE, FILL: begin
                // Accept this cycle's code first, so a same-cycle code is
                // part of whatever word leaves now.
                if (in_vld_i) begin
                    acc_w[cnt_q*CODE_W +: CODE_W] = in_code_i;
                    cnt_w = cnt_q + NW'(1);
                end
                if (out_free && (cnt_w == NW'(PACK_N) || (pend_q && cnt_w != '0))) begin
                    xfer      = 1'b1;
                    xfer_word = acc_w;
                    xfer_cnt  = cnt_w;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    acc_d = acc_w;
                    cnt_d = cnt_w;
                end
            end
            FULL: begin
                if (out_free) begin
                    xfer  = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                    // The slot vacated by the transfer takes the new code.
                    if (in_vld_i) begin
                        acc_d[CODE_W-1:0] = in_code_i;
                        cnt_d = NW'(1);
                    end
                end else if (in_vld_i && drop_q != '1) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        // A transfer consumes any pending flush. A fresh flush arms only if
        // something is left in the accumulator afterwards.
        pend_d = ((pend_q && !xfer) || flush_i) && (cnt_d != '0);

        if (cnt_d == '0)
            state_d = IDLE;
        else if (cnt_d == NW'(PACK_N))
            state_d = FULL;
        else
            state_d = FILL;

        out_vld_d  = (out_vld_q && !out_rdy_i) || xfer;
        out_data_d = xfer ? xfer_word : out_data_q;
        out_cnt_d  = xfer ? xfer_cnt  : out_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            pend_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_cnt_q  <= out_cnt_d;
            out_vld_q  <= out_vld_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
        end
    end

`ifdef CODE_PACKER_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_q <= 1'b0;
        else if (xfer)
            par_q <= ^xfer_word;
    end

    assign out_par_o = par_q;
`endif

    assign out_data_o = out_data_q;
    assign out_cnt_o  = out_cnt_q;
    assign out_vld_o  = out_vld_q;
    assign drop_cnt_o = drop_q;
    assign busy_o     = (cnt_q != '0) || out_vld_q || pend_q;

endmodule
